rr_mux4_arb: RTL



---
 rtl/rr_mux4_arb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rr_mux4_arb.sv
// rr_mux4_arb: four-requester round-robin arbiter that owns the select of a WIDTH-bit mux4.
// Define RR_MUX4_LOCK_EN to add the per-requester burst-lock input.

module rr_mux4_arb_mux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module rr_mux4_arb #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
`ifdef RR_MUX4_LOCK_EN
  input  logic [3:0]       lock,
`endif
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       xfer;
  logic       hold_lock;

  // First set bit of v, searching upward from start with 2-bit wrap.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef RR_MUX4_LOCK_EN
  assign hold_lock = lock[sel_q] & req[sel_q];
`else
  assign hold_lock = 1'b0;
`endif

  rr_mux4_arb_mux4 #(.WIDTH(WIDTH)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (sel_q),
    .y   (out_data)
  );

  assign sel = sel_q;

  // Handshake outputs and next-state; a locked winner keeps sel_q and ptr_q.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    out_valid = (state_q == GRANT) & req[sel_q];
    xfer      = out_valid & out_ready;
    gnt       = xfer ? (4'b0001 << sel_q) : 4'b0000;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_d   = rr_pick(req, ptr_q);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          state_d = IDLE;
        end else if (xfer && !hold_lock) begin
          ptr_d = sel_q + 2'd1;
          if (req != 4'b0000) sel_d = rr_pick(req, sel_q + 2'd1);
          else                state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule
